// File: rtl/asteroids_input_cond.sv
// asteroids_input_cond: merges PS/2 key events and the joystick word into the active-low BUTTON vector.
// Latency: key toggle -> BUTTON in 2 cycles, joy -> BUTTON in 1 cycle; coin is a fixed COIN_PULSE-cycle pulse.
// No backpressure: events are sampled every cycle; inhibit forces everything released.
module asteroids_input_cond #(
  parameter int COIN_PULSE = 625000,
  parameter int CNT_W      = 20
) (
  input  logic        clk_25,
  input  logic        RESET_L,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  input  logic        inhibit,
  output logic [7:0]  BUTTON,
  output logic        coin_busy
);

  // One held bit per mapped scancode, so two keys on one function never cancel.
  localparam int K_M     = 0;
  localparam int K_F1    = 1;
  localparam int K_F2    = 2;
  localparam int K_A     = 3;
  localparam int K_D     = 4;
  localparam int K_F3    = 5;
  localparam int K_L     = 6;
  localparam int K_K     = 7;
  localparam int K_ELEFT = 8;
  localparam int K_ERGT  = 9;
  localparam int K_CTRL  = 10;
  localparam int K_ALT   = 11;
  localparam int K_SPACE = 12;
  localparam int K_1     = 13;
  localparam int K_2     = 14;
  localparam int K_5     = 15;
  localparam int K_6     = 16;
  localparam int NKEYS   = 17;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_REL = 2'd2
  } coin_state_t;

  logic [NKEYS-1:0] held;
  logic [NKEYS-1:0] key_sel;
  logic             old_toggle;
  logic             key_event;

  logic right_lvl, left_lvl, start1_lvl, start2_lvl;
  logic fire_lvl, thrust_lvl, hyper_lvl, raw_coin;

  logic [4:0]       btn_hi;   // right, left, start1, start2, fire
  logic [1:0]       btn_lo;   // thrust, hyperspace
  logic             coin_n;
  logic             busy;
  coin_state_t      state;
  logic [CNT_W-1:0] cnt;

  // Joystick bits with no function in this game.
  logic unused_joy;
  assign unused_joy = ^{joy[15:9], joy[3:2]};

  assign key_event = (ps2_key[10] != old_toggle);

  // Exact 9-bit scancode match (bit 8 is the extended prefix) to a one-hot key select.
  always_comb begin
    key_sel = '0;
    case (ps2_key[8:0])
      9'h03A:  key_sel[K_M]     = 1'b1;
      9'h005:  key_sel[K_F1]    = 1'b1;
      9'h006:  key_sel[K_F2]    = 1'b1;
      9'h01C:  key_sel[K_A]     = 1'b1;
      9'h023:  key_sel[K_D]     = 1'b1;
      9'h004:  key_sel[K_F3]    = 1'b1;
      9'h04B:  key_sel[K_L]     = 1'b1;
      9'h042:  key_sel[K_K]     = 1'b1;
      9'h16B:  key_sel[K_ELEFT] = 1'b1;
      9'h174:  key_sel[K_ERGT]  = 1'b1;
      9'h014:  key_sel[K_CTRL]  = 1'b1;
      9'h011:  key_sel[K_ALT]   = 1'b1;
      9'h029:  key_sel[K_SPACE] = 1'b1;
      9'h016:  key_sel[K_1]     = 1'b1;
      9'h01E:  key_sel[K_2]     = 1'b1;
      9'h02E:  key_sel[K_5]     = 1'b1;
      9'h036:  key_sel[K_6]     = 1'b1;
      default: key_sel = '0;
    endcase
  end

  // Function levels: OR of every bound key plus the joystick bit.
  assign right_lvl  = held[K_D]  | held[K_ERGT]  | joy[0];
  assign left_lvl   = held[K_A]  | held[K_ELEFT] | joy[1];
  assign start1_lvl = held[K_F1] | held[K_1]     | joy[7];
  assign start2_lvl = held[K_F2] | held[K_2];
  assign fire_lvl   = held[K_M]  | held[K_CTRL]  | joy[4];
  assign thrust_lvl = held[K_L]  | held[K_ALT]   | joy[5];
  assign hyper_lvl  = held[K_K]  | held[K_SPACE] | joy[6];
  assign raw_coin   = held[K_F3] | held[K_5] | held[K_6] | joy[8];

  // Key-held tracking; old_toggle always follows the toggle so nothing stale decodes after reset/inhibit.
  always_ff @(posedge clk_25) begin
    old_toggle <= ps2_key[10];
    if (!RESET_L || inhibit) begin
      held <= '0;
    end else if (key_event) begin
      held <= (held & ~key_sel) | (key_sel & {NKEYS{ps2_key[9]}});
    end
  end

  // Registered active-low button outputs (coin bit comes from the pulse FSM).
  always_ff @(posedge clk_25) begin
    if (!RESET_L || inhibit) begin
      btn_hi <= 5'h1F;
      btn_lo <= 2'b11;
    end else begin
      btn_hi <= ~{right_lvl, left_lvl, start1_lvl, start2_lvl, fire_lvl};
      btn_lo <= ~{thrust_lvl, hyper_lvl};
    end
  end

  // Coin pulse shaper: one COIN_PULSE-cycle low pulse per press, then wait for release.
  always_ff @(posedge clk_25) begin
    if (!RESET_L || inhibit) begin
      state  <= IDLE;
      cnt    <= '0;
      coin_n <= 1'b1;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (raw_coin) begin
            state  <= PULSE;
            cnt    <= CNT_W'(COIN_PULSE - 1);
            coin_n <= 1'b0;
            busy   <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            coin_n <= 1'b1;
            if (raw_coin) begin
              state <= WAIT_REL;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        WAIT_REL: begin
          if (!raw_coin) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          coin_n <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  assign BUTTON    = {btn_hi, coin_n, btn_lo};
  assign coin_busy = busy;

endmodule

// File: tb/tb_asteroids_input_cond.sv
// Testbench for asteroids_input_cond: directed scenarios plus randomized traffic against a reference model.
// The model tracks held keys by scancode and the coin pulse as "cycles left low" plus a release latch.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_asteroids_input_cond;

  localparam int CP = 4;

  logic        clk_25;
  logic        RESET_L;
  logic [10:0] ps2_key;
  logic [15:0] joy;
  logic        inhibit;
  logic [7:0]  BUTTON;
  logic        coin_busy;

  int checks;
  int errors;

  asteroids_input_cond #(.COIN_PULSE(CP), .CNT_W(4)) dut (
    .clk_25   (clk_25),
    .RESET_L  (RESET_L),
    .ps2_key  (ps2_key),
    .joy      (joy),
    .inhibit  (inhibit),
    .BUTTON   (BUTTON),
    .coin_busy(coin_busy)
  );

  initial clk_25 = 1'b0;
  always #5 clk_25 = ~clk_25;

  // Key table: scancode and the BUTTON bit index of its function.
  localparam int KCODE [17] = '{'h03A, 'h005, 'h006, 'h01C, 'h023, 'h004, 'h04B, 'h042,
                                'h16B, 'h174, 'h014, 'h011, 'h029, 'h016, 'h01E, 'h02E, 'h036};
  localparam int KFN   [17] = '{3, 5, 4, 6, 7, 2, 1, 0, 6, 7, 3, 1, 0, 5, 4, 2, 2};

  // Reference model state
  bit         m_held [17];
  bit         m_old;
  logic [7:0] m_btn;
  bit         m_busy;
  int         m_left;   // remaining low cycles of the current coin pulse
  bit         m_wait;   // pulse done, coin still held

  // Advance model and DUT by one clock edge, then settle.
  task automatic step();
    bit [7:0] lvl;
    bit       raw;
    lvl = '0;
    for (int k = 0; k < 17; k++) if (m_held[k]) lvl[KFN[k]] = 1'b1;
    lvl[7] |= joy[0]; lvl[6] |= joy[1]; lvl[5] |= joy[7]; lvl[3] |= joy[4];
    lvl[2] |= joy[8]; lvl[1] |= joy[5]; lvl[0] |= joy[6];
    raw = lvl[2];
    if (!RESET_L || inhibit) begin
      for (int k = 0; k < 17; k++) m_held[k] = 1'b0;
      m_left = 0;
      m_wait = 1'b0;
      m_btn  = 8'hFF;
    end else begin
      if (m_wait) begin
        if (!raw) m_wait = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_wait = raw;
      end else if (raw) begin
        m_left = CP;
      end
      if (ps2_key[10] != m_old)
        for (int k = 0; k < 17; k++)
          if (KCODE[k] == int'(ps2_key[8:0])) m_held[k] = ps2_key[9];
      m_btn    = ~lvl;
      m_btn[2] = !(m_left > 0);
    end
    m_busy = (m_left > 0) || m_wait;
    m_old  = ps2_key[10];
    @(posedge clk_25);
    #1;
  endtask

  task automatic key_ev(input logic [8:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  task automatic test_reset();
    RESET_L = 1'b0;
    ps2_key = {1'b1, 1'b1, 9'h03A};
    joy = '0;
    inhibit = 1'b0;
    step(); step();
    checks++;
    if (BUTTON !== 8'hFF) begin errors++; $display("FAIL reset_button got %h want ff", BUTTON); end
    checks++;
    if (coin_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", coin_busy); end
    RESET_L = 1'b1;
    step(); step(); step();
    checks++;
    if (BUTTON !== 8'hFF) begin errors++; $display("FAIL reset_no_event got %h want ff", BUTTON); end
  endtask

  task automatic test_key_press();
    key_ev(9'h03A, 1'b1);
    step();
    checks++;
    if (BUTTON !== 8'hFF) begin errors++; $display("FAIL key_latency1 got %h want ff", BUTTON); end
    step();
    checks++;
    if (BUTTON !== 8'hF7) begin errors++; $display("FAIL key_press got %h want f7", BUTTON); end
    key_ev(9'h03A, 1'b0);
    step(); step();
    checks++;
    if (BUTTON !== 8'hFF) begin errors++; $display("FAIL key_release got %h want ff", BUTTON); end
  endtask

  task automatic test_overlap();
    key_ev(9'h014, 1'b1); step();
    key_ev(9'h03A, 1'b1); step(); step();
    key_ev(9'h03A, 1'b0); step(); step();
    checks++;
    if (BUTTON !== 8'hF7) begin errors++; $display("FAIL overlap_hold got %h want f7", BUTTON); end
    key_ev(9'h014, 1'b0); step(); step();
    checks++;
    if (BUTTON !== 8'hFF) begin errors++; $display("FAIL overlap_release got %h want ff", BUTTON); end
  endtask

  task automatic test_coin_hold();
    int lows, first;
    lows = 0; first = -1;
    joy = 16'h0100;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!BUTTON[2]) begin lows++; if (first < 0) first = i; end
      checks++;
      if (coin_busy !== 1'b1) begin errors++; $display("FAIL coin_hold_busy cyc %0d got %b want 1", i, coin_busy); end
    end
    checks++;
    if (lows != CP || first != 0) begin errors++; $display("FAIL coin_hold_len got %0d@%0d want %0d@0", lows, first, CP); end
    joy = '0; step();
    checks++;
    if (coin_busy !== 1'b0) begin errors++; $display("FAIL coin_release_busy got %b want 0", coin_busy); end
    lows = 0;
    joy = 16'h0100;
    for (int i = 0; i < 8; i++) begin step(); if (!BUTTON[2]) lows++; end
    joy = '0; step(); step();
    checks++;
    if (lows != CP) begin errors++; $display("FAIL coin_second_len got %0d want %0d", lows, CP); end
    checks++;
    if (coin_busy !== 1'b0) begin errors++; $display("FAIL coin_second_busy got %b want 0", coin_busy); end
  endtask

  task automatic test_coin_short();
    int lows;
    lows = 0;
    joy = 16'h0100; step(); joy = '0;
    if (!BUTTON[2]) lows++;
    key_ev(9'h02E, 1'b1);
    for (int i = 0; i < 10; i++) begin step(); if (!BUTTON[2]) lows++; end
    checks++;
    if (lows != CP) begin errors++; $display("FAIL coin_short_len got %0d want %0d", lows, CP); end
    key_ev(9'h02E, 1'b0); step(); step(); step();
    checks++;
    if (coin_busy !== 1'b0 || BUTTON !== 8'hFF) begin
      errors++; $display("FAIL coin_short_idle got %b/%h want 0/ff", coin_busy, BUTTON);
    end
  endtask

  task automatic test_inhibit();
    joy = 16'h0003;
    key_ev(9'h005, 1'b1);
    step(); step();
    checks++;
    if (BUTTON !== 8'h1F) begin errors++; $display("FAIL inh_before got %h want 1f", BUTTON); end
    inhibit = 1'b1; step();
    checks++;
    if (BUTTON !== 8'hFF) begin errors++; $display("FAIL inh_active got %h want ff", BUTTON); end
    inhibit = 1'b0;
    checks++;
    if (BUTTON !== 8'hFF) begin errors++; $display("FAIL inh_fall_hold got %h want ff", BUTTON); end
    step();
    checks++;
    if (BUTTON !== 8'h3F) begin errors++; $display("FAIL inh_resume got %h want 3f", BUTTON); end
    joy = '0; step();
    checks++;
    if (BUTTON !== 8'hFF) begin errors++; $display("FAIL inh_clear got %h want ff", BUTTON); end
  endtask

  task automatic test_reset_mid_pulse();
    joy = 16'h0100; step(); step();
    checks++;
    if (BUTTON !== 8'hFB) begin errors++; $display("FAIL midp_pulse got %h want fb", BUTTON); end
    RESET_L = 1'b0; step();
    checks++;
    if (BUTTON !== 8'hFF || coin_busy !== 1'b0) begin
      errors++; $display("FAIL midp_reset got %h/%b want ff/0", BUTTON, coin_busy);
    end
    RESET_L = 1'b1; joy = '0; step();
  endtask

  task automatic test_left_right();
    key_ev(9'h16B, 1'b1);
    joy = 16'h0001;
    step();
    checks++;
    if (BUTTON !== 8'h7F) begin errors++; $display("FAIL lr_joy got %h want 7f", BUTTON); end
    step();
    checks++;
    if (BUTTON !== 8'h3F) begin errors++; $display("FAIL lr_both got %h want 3f", BUTTON); end
    key_ev(9'h16B, 1'b0); joy = '0; step(); step();
    checks++;
    if (BUTTON !== 8'hFF) begin errors++; $display("FAIL lr_release got %h want ff", BUTTON); end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 25) begin
        if (r < 22) key_ev(9'(KCODE[$urandom_range(0, 16)]), 1'($urandom_range(0, 1)));
        else        key_ev(9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 9) == 0) joy = 16'($urandom) & 16'($urandom);
      inhibit = ($urandom_range(0, 39) == 0);
      step();
      checks++;
      if (BUTTON !== m_btn || coin_busy !== m_busy) begin
        errors++;
        $display("FAIL random cyc %0d got %h/%b want %h/%b", i, BUTTON, coin_busy, m_btn, m_busy);
      end
    end
    inhibit = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_old  = 1'b0;
    m_btn  = 8'hFF;
    m_busy = 1'b0;
    m_left = 0;
    m_wait = 1'b0;
    for (int k = 0; k < 17; k++) m_held[k] = 1'b0;
    #1;
    test_reset();
    test_key_press();
    test_overlap();
    test_coin_hold();
    test_coin_short();
    test_inhibit();
    test_reset_mid_pulse();
    test_left_right();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
